// File: rtl/zstr_fifo.sv
// zstr_fifo: QL-entry circular FIFO between a z-stream source and drain; push to pop latency 1 cycle.
// Backpressure: zi_rdy drops while full and zo_vld drops while empty; both are decoded from the registered count only.
module zstr_fifo #(
   parameter int             BW = 1,
   parameter logic [BW-1:0]  XZ = {BW{1'bx}},
   parameter int             QL = 4,
   parameter int             QW = $clog2(QL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          zi_vld,
   input  logic [BW-1:0] zi_bus,
   output logic          zi_rdy,
   output logic          zo_vld,
   output logic [BW-1:0] zo_bus,
   input  logic          zo_rdy,
   output logic [QW:0]   cnt
);

   localparam logic [QW-1:0] LAST = QW'(QL - 1);
   localparam logic [QW:0]   FULL = (QW + 1)'(QL);

   logic [QW-1:0] wp_q, wp_d;
   logic [QW-1:0] rp_q, rp_d;
   logic [QW:0]   cnt_q, cnt_d;
   logic [BW-1:0] mem_q [QL];
   logic [BW-1:0] mem_d [QL];
   logic          push, pop;

   // Ready/valid come straight from the count register, so neither side sees the other combinationally.
   always_comb begin
      zi_rdy = (cnt_q != FULL);
      zo_vld = (cnt_q != '0);
      zo_bus = zo_vld ? mem_q[rp_q] : XZ;
      cnt    = cnt_q;
      push   = zi_vld && zi_rdy;
      pop    = zo_vld && zo_rdy;
   end

   // Explicit wrap keeps non-power-of-two depths correct.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      mem_d = mem_q;
      if (push) begin
         mem_d[wp_q] = zi_bus;
         wp_d        = (wp_q == LAST) ? '0 : wp_q + QW'(1);
      end
      if (pop) begin
         rp_d = (rp_q == LAST) ? '0 : rp_q + QW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (QW + 1)'(1);
         2'b01:   cnt_d = cnt_q - (QW + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is deliberately left out of reset; the cleared count makes old contents unreachable.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: doc/zstr_fifo.md
# zstr_fifo

Synchronous z-stream FIFO buffer. It sits between a `zstr_src` producer and a `zstr_drn` consumer and decouples their `vld`/`rdy` handshakes. Data words are stored in a `QL`-entry circular queue and come out in order. A fill count is exported for flow monitoring.

## Interface
Parameters:
- `BW`, 1, bus width of `z_bus` words
- `XZ`, 1'bx, value driven on `zo_bus` when `zo_vld` is low
- `QL`, 4, queue length in words; legal range is QL ≥ 2
- `QW`, $clog2(QL), queue address width

Ports:
- `clk`  in  1  system clock, all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `zi_vld`  in  1  input transfer valid (from upstream source)
- `zi_bus`  in  BW  input data word
- `zi_rdy`  out  1  input transfer ready
- `zo_vld`  out  1  output transfer valid (to downstream drain)
- `zo_bus`  out  BW  output data word
- `zo_rdy`  in  1  output transfer ready
- `cnt`  out  QW+1  current number of stored words, 0..QL

## Operation
- Transfer rule, both sides: a word moves on a rising `clk` edge where `vld && rdy` is high.
  - Input side: a transfer is a push.
  - Output side: a transfer is a pop.
  - No other condition moves data.
- State registers:
  - write pointer `wp` (QW bits)
  - read pointer `rp` (QW bits)
  - `cnt` (QW+1 bits)
  - storage array of `QL` × `BW`
- Push: write `zi_bus` to `mem[wp]`. Then set `wp` to `wp+1`, or to 0 when `wp == QL-1`. Wrap is explicit, so `QL` need not be a power of two.
- Pop: set `rp` to `rp+1` with the same wrap rule.
- Count update on each edge:
  - push only: `cnt+1`
  - pop only: `cnt-1`
  - both or neither: unchanged
- `zi_rdy = (cnt != QL)`, combinational from the `cnt` register only. It never depends on `zo_rdy`.
- `zo_vld = (cnt != 0)`, combinational from the `cnt` register only. It never depends on `zi_vld`.
- `zo_bus = mem[rp]` while `zo_vld` is high, otherwise `XZ`.
- Full (`cnt == QL`):
  - `zi_rdy` is 0, so no push is possible, even if a pop happens in the same cycle.
  - The freed slot becomes available on the next cycle.
- Empty (`cnt == 0`):
  - `zo_vld` is 0, so no pop is possible.
  - A push in the same cycle is not visible at the output until the next cycle. There is no fall-through path.
- Simultaneous push and pop with 0 < `cnt` < QL: both complete and `cnt` is unchanged.
- Asynchronous reset:
  - `wp`, `rp` and `cnt` clear to 0.
  - Storage contents are not reset.
  - Any stored words are discarded.
- Reset values:
  - `zo_vld` = 0, `zo_bus` = `XZ`
  - `zi_rdy` = 1, `cnt` = 0
- Handshakes presented while `rst` is high have no effect.
- Once `vld` is asserted on a side, the partner holds `vld` and `bus` stable until the transfer. The FIFO guarantees this on its output side: `zo_vld` only drops through a pop, and `zo_bus` only changes through a pop.

## Timing
- Latency from push to `zo_vld` high on an empty FIFO: 1 cycle. A word pushed at edge N is poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained, for any occupancy 1..QL-1.
- Full recovery: after a pop from a full FIFO, `zi_rdy` rises in the same cycle following that edge, 1 cycle.
- No combinational path from input side to output side, or from output side to input side.
- `cnt` is registered and reflects all transfers up to the last edge.
- Reset asserts immediately, without waiting for `clk`. Deassertion must be synchronous to `clk` externally; release takes effect at the first edge after `rst` falls.

## Test plan
Scenarios use `QL`=4 and `BW`=8.
- Reset, then idle → `cnt`=0, `zo_vld`=0, `zo_bus`=`XZ`, `zi_rdy`=1. Hold `zi_vld`=1 during reset → still `cnt`=0 after release.
- Fill with `zo_rdy`=0, pushing 0x11, 0x22, 0x33, 0x44 on consecutive edges → `cnt` steps 1,2,3,4. `zi_rdy`=0 after the 4th edge. A 5th word 0x55 is held off and not stored.
- Drain the full FIFO with `zo_rdy`=1 and `zi_vld`=0 → `zo_bus` shows 0x11, 0x22, 0x33, 0x44 on successive cycles. Then `zo_vld`=0 and `cnt`=0.
- Full with simultaneous `zi_vld`=1 and `zo_rdy`=1 → pop of 0x11, no push that cycle, `cnt`=3. The push of 0x55 happens on the next edge, `cnt` returns to 4.
- Streaming with both sides always ready over 10 words 0x00..0x09, starting empty → first pop one cycle after first push. Output order matches input order. `wp` and `rp` wrap twice. `cnt` stays at 1 during steady state.
- Assert `rst` mid-stream with `cnt`=3, asynchronously between edges → `zo_vld`=0, `zi_rdy`=1, `cnt`=0 immediately. After release, the first push of 0xA5 is the first word popped.
